capture_ram: RTL

- Write-side counterpart to the sine lookup ROM: records an incoming 8-bit sample stream into on-chip RAM.
- Plays the stream back at a programmable sample delay (delay line / echo source).
- Supports arm/trigger capture: after a trigger, recording continues for a set number of samples and then freezes so the buffer can be inspected.
- Sits between the sample source (ROM output or ADC) and the waveform/audio output in the signal-generator path.

---
 rtl/capture_ram_pkg.sv | 14 +
 rtl/capture_ram_ram_sdp.sv | 38 +++
 rtl/capture_ram.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/capture_ram_pkg.sv
// Shared types and default widths for the capture_ram delay-line / trigger recorder.
package capture_ram_pkg;

    localparam int ADDRESS_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        POST,
        FROZEN
    } state_t;

endpackage

// File: rtl/capture_ram_ram_sdp.sv
// Simple dual-port RAM: one write port, NUM_READ registered read-first read ports.
// Only the read registers are reset; the storage array keeps its contents.
module ram_sdp
    import capture_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int NUM_READ      = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    we,
    input  logic [ADDRESS_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]                   wr_data,
    input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0]  rd_addr,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking update of mem means a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_READ; i++) begin
                rd_data[i] <= mem[rd_addr[i]];
            end
        end
    end

endmodule

// File: rtl/capture_ram.sv
// Sample recorder with delayed playback and arm/trigger freeze.
// Define CAPTURE_RAM_PORT2_EN to add a second independent delayed read port.
module capture_ram
    import capture_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     arm,
    input  logic                     trig,
    input  logic [ADDRESS_WIDTH-1:0] post_len,
    input  logic [ADDRESS_WIDTH-1:0] delay,
`ifdef CAPTURE_RAM_PORT2_EN
    input  logic [ADDRESS_WIDTH-1:0] delay2,
    output logic [DATA_WIDTH-1:0]    dout2,
    output logic                     dout2_valid,
`endif
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic [ADDRESS_WIDTH-1:0] trig_addr,
    output logic                     busy,
    output logic                     done
);

`ifdef CAPTURE_RAM_PORT2_EN
    localparam int NUM_READ = 2;
`else
    localparam int NUM_READ = 1;
`endif

    localparam logic [ADDRESS_WIDTH:0] FILL_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    state_t state;
    state_t state_next;

    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH:0]   fill;
    logic [ADDRESS_WIDTH-1:0] post_cnt;
    logic                     we;
    logic                     clear;
    logic                     capture;

    logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] delays;
    logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] rd_addr;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]    rd_data;
    logic [NUM_READ-1:0]                    rd_valid;

    always_comb begin
        state_next = state;
        we         = 1'b0;
        clear      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE, FROZEN: begin
                if (arm) begin
                    state_next = RECORD;
                    clear      = 1'b1;
                end
            end
            RECORD: begin
                we = en;
                if (trig) begin
                    capture    = 1'b1;
                    state_next = (post_len == '0) ? FROZEN : POST;
                end
            end
            POST: begin
                we = en;
                if (en && post_cnt == ADDRESS_WIDTH'(1)) begin
                    state_next = FROZEN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The trigger-cycle write does not count toward post_len: post_cnt only
    // starts decrementing once the state register reads POST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                wr_ptr <= '0;
                fill   <= '0;
            end else if (we) begin
                wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
                if (fill != FILL_MAX) begin
                    fill <= fill + (ADDRESS_WIDTH+1)'(1);
                end
            end
            if (capture) begin
                trig_addr <= wr_ptr;
                post_cnt  <= post_len;
            end else if (state == POST && en) begin
                post_cnt <= post_cnt - ADDRESS_WIDTH'(1);
            end
        end
    end

    assign delays[0] = delay;
`ifdef CAPTURE_RAM_PORT2_EN
    assign delays[1] = delay2;
`endif

    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_addr[i] = wr_ptr - ADDRESS_WIDTH'(1) - delays[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_READ; i++) begin
                rd_valid[i] <= ({1'b0, delays[i]} < fill);
            end
        end
    end

    ram_sdp #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_READ      (NUM_READ)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign dout       = rd_data[0];
    assign dout_valid = rd_valid[0];
`ifdef CAPTURE_RAM_PORT2_EN
    assign dout2       = rd_data[1];
    assign dout2_valid = rd_valid[1];
`endif

    assign busy = (state == RECORD) || (state == POST);
    assign done = (state == FROZEN);

endmodule
